// File: rtl/display_scan_controller_if.sv
// Signal bundle between the display scan controller and its environment.
// brightness exists only when SCAN_BRIGHTNESS_PWM_EN is defined.
interface display_scan_controller_if;
  logic       run;
  logic [7:0] digit_mask;
  logic [2:0] S;
  logic       enable;
  logic       digit_start;
  logic       frame_done;

`ifdef SCAN_BRIGHTNESS_PWM_EN
  logic [2:0] brightness;

  modport master (
    output run, digit_mask, brightness,
    input  S, enable, digit_start, frame_done
  );

  modport slave (
    input  run, digit_mask, brightness,
    output S, enable, digit_start, frame_done
  );
`else
  modport master (
    output run, digit_mask,
    input  S, enable, digit_start, frame_done
  );

  modport slave (
    input  run, digit_mask,
    output S, enable, digit_start, frame_done
  );
`endif
endinterface

// File: rtl/display_scan_controller.sv
// Seven-segment digit scan controller: BLANK gap then SHOW window per active digit.
// Optional macro SCAN_BRIGHTNESS_PWM_EN adds brightness PWM gating of enable during SHOW.
module display_scan_controller #(
  parameter int TICK_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  display_scan_controller_if.slave bus
);

  localparam int MAX_LEN = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICK_DIV - 1);

  // state | meaning
  // IDLE  | not scanning, enable low, S held
  // BLANK | enable low anti-ghost gap before the selected digit
  // SHOW  | enable high (or PWM-gated) window for the selected digit
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t           state_q;
  logic [2:0]       sel_q;
  logic             enable_q;
  logic             digit_start_q;
  logic             frame_done_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0] first_sel;
  logic       first_found;
  logic [2:0] nxt_sel;
  logic       nxt_found;
  logic       nxt_wrap;
  logic [2:0] probe;
  logic       mask_any;
  logic       show_en;

  assign mask_any = |bus.digit_mask;

  // Circular search for the next set mask bit after sel_q; lands on sel_q itself if it is the only one.
  always_comb begin
    first_sel   = '0;
    first_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!first_found && bus.digit_mask[i]) begin
        first_sel   = 3'(i);
        first_found = 1'b1;
      end
    end

    nxt_sel   = sel_q;
    nxt_found = 1'b0;
    probe     = '0;
    for (int k = 1; k <= 8; k++) begin
      probe = sel_q + 3'(k);
      if (!nxt_found && bus.digit_mask[probe]) begin
        nxt_sel   = probe;
        nxt_found = 1'b1;
      end
    end
    nxt_wrap = (nxt_sel <= sel_q);
  end

`ifdef SCAN_BRIGHTNESS_PWM_EN
  logic [2:0] pwm_cnt_q;
  logic [2:0] pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt_q + 3'd1;
  // enable is registered, so gate with the count that will be current next cycle.
  assign show_en   = (pwm_cnt_d <= bus.brightness);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  assign show_en = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      enable_q      <= 1'b0;
      digit_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      cnt_q         <= '0;
    end else begin
      digit_start_q <= 1'b0;
      frame_done_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          enable_q <= 1'b0;
          cnt_q    <= '0;
          if (bus.run && mask_any) begin
            state_q <= ST_BLANK;
            sel_q   <= first_sel;
          end
        end

        ST_BLANK: begin
          enable_q <= 1'b0;
          if (!bus.run || !mask_any) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == BLANK_LAST) begin
            state_q       <= ST_SHOW;
            cnt_q         <= '0;
            enable_q      <= show_en;
            digit_start_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_SHOW: begin
          if (!bus.run || !mask_any) begin
            state_q  <= ST_IDLE;
            enable_q <= 1'b0;
            cnt_q    <= '0;
          end else if (!bus.digit_mask[sel_q] || cnt_q == SHOW_LAST) begin
            state_q      <= ST_BLANK;
            sel_q        <= nxt_sel;
            frame_done_q <= nxt_wrap;
            enable_q     <= 1'b0;
            cnt_q        <= '0;
          end else begin
            cnt_q    <= cnt_q + 1'b1;
            enable_q <= show_en;
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          enable_q <= 1'b0;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  assign bus.S           = sel_q;
  assign bus.enable      = enable_q;
  assign bus.digit_start = digit_start_q;
  assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller with TICK_DIV=4, BLANK_CYCLES=2.
// Expected per-cycle outputs are queued when stimulus is applied and compared as cycles elapse.
module tb_display_scan_controller;

  localparam int TD = 4;
  localparam int BC = 2;

  typedef struct packed {
    logic [2:0] s;
    logic       en;
    logic       ds;
    logic       fd;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  obs_t exp_q[$];
  obs_t e;
  obs_t got;
  int   cyc;

  display_scan_controller_if bus ();

  display_scan_controller #(
    .TICK_DIV     (TD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef SCAN_BRIGHTNESS_PWM_EN
  logic [2:0] tb_pwm;
  always @(posedge clk or posedge reset) begin
    if (reset) tb_pwm <= 3'd0;
    else       tb_pwm <= tb_pwm + 3'd1;
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "simulation time limit");
  end

  task automatic push(input logic [2:0] s, input logic en, input logic ds, input logic fd);
    obs_t o;
    o.s = s; o.en = en; o.ds = ds; o.fd = fd;
    exp_q.push_back(o);
  endtask

  task automatic push_slot(input logic [2:0] s, input logic fd);
    push(s, 1'b0, 1'b0, fd);
    for (int i = 1; i < BC; i++) push(s, 1'b0, 1'b0, 1'b0);
    push(s, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < TD; i++) push(s, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.run = 1'b0;
    bus.digit_mask = 8'h00;
`ifdef SCAN_BRIGHTNESS_PWM_EN
    bus.brightness = 3'd7;
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    bus.digit_mask = 8'h20;
    bus.run = 1'b1;
    push(3'd5, 0, 0, 0); push(3'd5, 0, 0, 0); push(3'd5, 1, 1, 0); push(3'd5, 1, 0, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {bus.S, bus.enable, bus.digit_start, bus.frame_done};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset_pre cyc=%0d got S=%0d en=%b ds=%b fd=%b want S=%0d en=%b ds=%b fd=%b",
                 cyc, got.s, got.en, got.ds, got.fd, e.s, e.en, e.ds, e.fd);
      end
      cyc++;
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.S !== 3'd0) begin failures++; $display("FAIL reset_async_S got=%0d want=0", bus.S); end
    checks++;
    if (bus.enable !== 1'b0) begin failures++; $display("FAIL reset_async_en got=%b want=0", bus.enable); end
    checks++;
    if ({bus.digit_start, bus.frame_done} !== 2'b00) begin
      failures++; $display("FAIL reset_async_pulses got=%b want=00", {bus.digit_start, bus.frame_done});
    end
    bus.run = 1'b0;
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) push(3'd0, 0, 0, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {bus.S, bus.enable, bus.digit_start, bus.frame_done};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got S=%0d en=%b ds=%b fd=%b want S=%0d en=%b ds=%b fd=%b",
                 cyc, got.s, got.en, got.ds, got.fd, e.s, e.en, e.ds, e.fd);
      end
      cyc++;
    end
  endtask

  task automatic test_full_mask();
    apply_reset();
    bus.digit_mask = 8'hFF;
    bus.run = 1'b1;
    push_slot(3'd0, 1'b0);
    for (int f = 0; f < 2; f++) begin
      for (int d = 1; d < 8; d++) push_slot(3'(d), 1'b0);
      push_slot(3'd0, 1'b1);
    end
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {bus.S, bus.enable, bus.digit_start, bus.frame_done};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL full_mask cyc=%0d got S=%0d en=%b ds=%b fd=%b want S=%0d en=%b ds=%b fd=%b",
                 cyc, got.s, got.en, got.ds, got.fd, e.s, e.en, e.ds, e.fd);
      end
      cyc++;
    end
  endtask

  task automatic test_sparse_mask();
    apply_reset();
    bus.digit_mask = 8'b1001_0010;
    bus.run = 1'b1;
    push_slot(3'd1, 0); push_slot(3'd4, 0); push_slot(3'd7, 0);
    push_slot(3'd1, 1); push_slot(3'd4, 0); push_slot(3'd7, 0);
    push_slot(3'd1, 1);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {bus.S, bus.enable, bus.digit_start, bus.frame_done};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL sparse_mask cyc=%0d got S=%0d en=%b ds=%b fd=%b want S=%0d en=%b ds=%b fd=%b",
                 cyc, got.s, got.en, got.ds, got.fd, e.s, e.en, e.ds, e.fd);
      end
      cyc++;
    end
  endtask

  task automatic test_single_digit();
    apply_reset();
    bus.digit_mask = 8'b0000_1000;
    bus.run = 1'b1;
    push_slot(3'd3, 0);
    for (int i = 0; i < 3; i++) push_slot(3'd3, 1);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {bus.S, bus.enable, bus.digit_start, bus.frame_done};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL single_digit cyc=%0d got S=%0d en=%b ds=%b fd=%b want S=%0d en=%b ds=%b fd=%b",
                 cyc, got.s, got.en, got.ds, got.fd, e.s, e.en, e.ds, e.fd);
      end
      cyc++;
    end
  endtask

  // Drop run mid-SHOW, restart, then drop run exactly on a wrapping end-of-window.
  task automatic test_run_drop();
    apply_reset();
    bus.digit_mask = 8'hFF;
    bus.run = 1'b1;
    push_slot(3'd0, 0); push_slot(3'd1, 0);
    push(3'd2, 0, 0, 0); push(3'd2, 0, 0, 0); push(3'd2, 1, 1, 0); push(3'd2, 1, 0, 0);
    for (int phase = 0; phase < 4; phase++) begin
      cyc = 0;
      while (exp_q.size() > 0) begin
        @(posedge clk); #1;
        e = exp_q.pop_front();
        got = {bus.S, bus.enable, bus.digit_start, bus.frame_done};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL run_drop ph=%0d cyc=%0d got S=%0d en=%b ds=%b fd=%b want S=%0d en=%b ds=%b fd=%b",
                   phase, cyc, got.s, got.en, got.ds, got.fd, e.s, e.en, e.ds, e.fd);
        end
        cyc++;
      end
      case (phase)
        0: begin
          bus.run = 1'b0;
          for (int i = 0; i < 3; i++) push(3'd2, 0, 0, 0);
        end
        1: begin
          bus.run = 1'b1;
          push_slot(3'd0, 0); push_slot(3'd1, 0);
        end
        2: begin
          bus.run = 1'b0;
          push(3'd1, 0, 0, 0);
          bus.digit_mask = 8'h02;
        end
        default: begin
          bus.run = 1'b1;
          push_slot(3'd1, 0);
          cyc = 0;
          while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus.S, bus.enable, bus.digit_start, bus.frame_done};
            checks++;
            if (got !== e) begin
              failures++;
              $display("FAIL run_drop_single cyc=%0d got S=%0d en=%b ds=%b fd=%b want S=%0d en=%b ds=%b fd=%b",
                       cyc, got.s, got.en, got.ds, got.fd, e.s, e.en, e.ds, e.fd);
            end
            cyc++;
          end
          bus.run = 1'b0;
          push(3'd1, 0, 0, 0); push(3'd1, 0, 0, 0);
        end
      endcase
    end
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {bus.S, bus.enable, bus.digit_start, bus.frame_done};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL run_drop_end cyc=%0d got S=%0d en=%b ds=%b fd=%b want S=%0d en=%b ds=%b fd=%b",
                 cyc, got.s, got.en, got.ds, got.fd, e.s, e.en, e.ds, e.fd);
      end
      cyc++;
    end
  endtask

  // Clearing the shown digit's mask bit ends SHOW early; from digit 7 it wraps and flags the frame.
  task automatic test_mask_clear();
    apply_reset();
    bus.digit_mask = 8'h81;
    bus.run = 1'b1;
    push_slot(3'd0, 0);
    push(3'd7, 0, 0, 0); push(3'd7, 0, 0, 0); push(3'd7, 1, 1, 0);
    for (int phase = 0; phase < 2; phase++) begin
      cyc = 0;
      while (exp_q.size() > 0) begin
        @(posedge clk); #1;
        e = exp_q.pop_front();
        got = {bus.S, bus.enable, bus.digit_start, bus.frame_done};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL mask_clear ph=%0d cyc=%0d got S=%0d en=%b ds=%b fd=%b want S=%0d en=%b ds=%b fd=%b",
                   phase, cyc, got.s, got.en, got.ds, got.fd, e.s, e.en, e.ds, e.fd);
        end
        cyc++;
      end
      if (phase == 0) begin
        bus.digit_mask = 8'h01;
        push_slot(3'd0, 1); push_slot(3'd0, 1);
      end
    end
  endtask

  // Mask going to zero in SHOW and in BLANK returns to IDLE with S held.
  task automatic test_zero_mask();
    apply_reset();
    bus.digit_mask = 8'h04;
    bus.run = 1'b1;
    push(3'd2, 0, 0, 0); push(3'd2, 0, 0, 0); push(3'd2, 1, 1, 0);
    for (int phase = 0; phase < 3; phase++) begin
      cyc = 0;
      while (exp_q.size() > 0) begin
        @(posedge clk); #1;
        e = exp_q.pop_front();
        got = {bus.S, bus.enable, bus.digit_start, bus.frame_done};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL zero_mask ph=%0d cyc=%0d got S=%0d en=%b ds=%b fd=%b want S=%0d en=%b ds=%b fd=%b",
                   phase, cyc, got.s, got.en, got.ds, got.fd, e.s, e.en, e.ds, e.fd);
        end
        cyc++;
      end
      if (phase == 0) begin
        bus.digit_mask = 8'h00;
        for (int i = 0; i < 6; i++) push(3'd2, 0, 0, 0);
      end else if (phase == 1) begin
        bus.digit_mask = 8'h04;
        @(posedge clk); #1;
        bus.digit_mask = 8'h00;
        for (int i = 0; i < 6; i++) push(3'd2, 0, 0, 0);
      end
    end
  endtask

`ifdef SCAN_BRIGHTNESS_PWM_EN
  task automatic test_brightness();
    logic [2:0] p;
    apply_reset();
    bus.brightness = 3'd1;
    bus.digit_mask = 8'h08;
    bus.run = 1'b1;
    for (int k = 1; k <= 2 * (BC + TD); k++) begin
      int pos;
      pos = (k - 1) % (BC + TD);
      p = tb_pwm + 3'(k);
      if (pos < BC) push(3'd3, 1'b0, 1'b0, (pos == 0 && k > 1));
      else          push(3'd3, (p <= 3'd1), (pos == BC), 1'b0);
    end
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {bus.S, bus.enable, bus.digit_start, bus.frame_done};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL brightness cyc=%0d got S=%0d en=%b ds=%b fd=%b want S=%0d en=%b ds=%b fd=%b",
                 cyc, got.s, got.en, got.ds, got.fd, e.s, e.en, e.ds, e.fd);
      end
      cyc++;
    end
  endtask
`endif

  initial begin
    bus.run = 1'b0;
    bus.digit_mask = 8'h00;
`ifdef SCAN_BRIGHTNESS_PWM_EN
    bus.brightness = 3'd7;
`endif
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_single_digit();
    test_run_drop();
    test_mask_clear();
    test_zero_mask();
`ifdef SCAN_BRIGHTNESS_PWM_EN
    test_brightness();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexes up to 8 seven-segment digit positions of the alarm-clock display.
- Drives the 3-bit select and active-high enable of the 3-to-8 digit decoder.
- Steps through active digits in a fixed cycle: a blanking gap, then a show window, per digit.
- Skips masked-off digits and flags each completed frame to the segment-data logic.

Parameters:
- TICK_DIV, 1000, clock cycles per SHOW window (enable high); minimum 1.
- BLANK_CYCLES, 16, clock cycles of BLANK gap (enable low) before each digit; minimum 1; anti-ghosting.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  scanning allowed while high.
- digit_mask  input  8  bit i = 1 means digit i is displayed; sampled when choosing the next digit and every SHOW cycle.
- S  output  3  digit select to decoder, registered.
- enable  output  1  decoder enable, active high, registered.
- digit_start  output  1  one-cycle pulse coincident with the first enable-high cycle of each SHOW.
- frame_done  output  1  one-cycle pulse at the end of the last active digit's SHOW.

Behaviour:
- Reset (async, immediate): state=IDLE, S=0, enable=0, digit_start=0, frame_done=0, counters=0.
- All outputs registered; decisions below apply at the rising clk edge.
- States: IDLE, BLANK, SHOW.
- next(x): lowest set index of digit_mask searching x+1..7, then wrapping 0..x; returns x if x is the only set bit.
- wrap(x): true when next(x) <= x.
- first: lowest set index of digit_mask.
- IDLE:
  - Outputs: enable=0, S held.
  - If run=1 and digit_mask!=0: go to BLANK, S=first, cnt=0.
- BLANK:
  - enable=0 for exactly BLANK_CYCLES cycles.
  - Then go to SHOW with enable=1, digit_start=1, cnt=0.
- SHOW:
  - enable=1 for exactly TICK_DIV cycles.
  - Slot period = BLANK_CYCLES+TICK_DIV.
  - At end of window: go to BLANK, S=next(S), frame_done=1 if wrap(S).
- Mask bit S cleared during SHOW: end SHOW on the next edge. Go to BLANK, S=next(S), enable=0; frame_done follows the same wrap rule.
- digit_mask becomes 0 in BLANK or SHOW: go to IDLE next edge; enable=0, S held, no frame_done.
- run=0 in BLANK or SHOW: go to IDLE next edge; enable=0, S held, no pulses.
- On restart from IDLE, scanning always begins at first.
- Single active digit: S constant; BLANK/SHOW still alternate; frame_done every slot.
- Simultaneous end-of-window and run=0: run=0 wins (IDLE, no frame_done).
- Counter width: clog2 of max(TICK_DIV, BLANK_CYCLES); no overflow.
- digit_start and frame_done never assert in IDLE.
- digit_start and frame_done never assert in the same cycle.
- enable never high in BLANK or IDLE.

Optional Feature:
- Macro: SCAN_BRIGHTNESS_PWM_EN.
- When defined:
  - Adds input port brightness [2:0].
  - A free-running 3-bit pwm_cnt increments every clk and resets to 0.
  - During SHOW, enable = (pwm_cnt <= brightness); brightness=7 means always on.
  - SHOW length, slot period, digit_start and frame_done timing are unchanged.
  - digit_start still pulses on the first SHOW cycle, even if enable is low that cycle.
- When undefined: the port is absent and enable is constant 1 throughout SHOW.

Test Plan:
All scenarios use TICK_DIV=4, BLANK_CYCLES=2.
- Reset asserted mid-SHOW (S=5, enable=1) -> S=0, enable=0, pulses 0 without waiting for clk; after release, state IDLE.
- run=1, digit_mask=8'hFF -> one IDLE edge, then S=0 with 2 enable-low + 4 enable-high cycles, then S=1…7; digit_start every 6 cycles; frame_done once per 48 cycles, with S changing 7->0.
- digit_mask=8'b10010010 -> S sequence 1,4,7,1,…; frame_done only on the 7->1 step; period 18 cycles.
- digit_mask=8'b00001000 -> S stays 3; enable pattern 0,0,1,1,1,1 repeating; frame_done every 6 cycles.
- Drop run during 2nd SHOW cycle of digit 2 -> enable=0 next cycle, IDLE, S=2, no frame_done. Re-raise run with digit_mask=8'hFF -> restart at S=0.
- run=1, digit_mask=0 -> remains IDLE, enable=0. With SCAN_BRIGHTNESS_PWM_EN and brightness=1 -> enable high only when pwm_cnt is 0 or 1 within SHOW.
